// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF stage: branch opcodes, reset defaults and FSM encoding.
// Used by if_fetch_stage and fetch_perf_counters (FETCH_PERF_CNT_EN build).
package if_fetch_stage_pkg;

    localparam logic [5:0]  BEQ_OP            = 6'b000100;
    localparam logic [5:0]  BNE_OP            = 6'b000101;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_cond_branch(input logic [31:0] instr);
        return (instr[31:26] == BEQ_OP) || (instr[31:26] == BNE_OP);
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch/bubble/stall event counters; only built when FETCH_PERF_CNT_EN is defined.
// Counters wrap at 2^32 and hold while count_en is low (halted).
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_en,
    input  logic        inc_fetch,
    input  logic        inc_bubble,
    input  logic        inc_stall,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_stall
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch  <= '0;
            perf_bubble <= '0;
            perf_stall  <= '0;
        end else if (count_en) begin
            if (inc_fetch)  perf_fetch  <= perf_fetch + 32'd1;
            if (inc_bubble) perf_bubble <= perf_bubble + 32'd1;
            if (inc_stall)  perf_stall  <= perf_stall + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC register, boot/run/halt FSM and the IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_stall
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_plus4;
    logic         load_fetch, load_bubble;

    assign pc_plus4  = pc_q + INSTR_BYTES;
    assign imem_addr = pc_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load_fetch  = 1'b0;
        load_bubble = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                load_bubble = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (stall) begin
                    // hazard unit re-presents redirect/halt once the stall drops
                end else if (redirect_valid) begin
                    pc_d        = redirect_pc & ~32'h3;
                    load_bubble = 1'b1;
                end else if (is_cond_branch(if_id_instr)) begin
                    load_bubble = 1'b1;
                end else if (halt_req) begin
                    load_bubble = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    pc_d       = pc_plus4;
                    load_fetch = 1'b1;
                end
            end
            S_HALT: load_bubble = 1'b1;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halted  <= (state_d == S_HALT);
        end
    end

    // Bubbles keep the current PC in if_id_pc/if_id_pc4 as a debug breadcrumb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'h0;
            if_id_pc4   <= INSTR_BYTES;
            if_id_valid <= 1'b0;
        end else if (load_fetch || load_bubble) begin
            if_id_instr <= load_fetch ? imem_instr : NOP_INSTR;
            if_id_pc    <= pc_q;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= load_fetch;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_en    (state_q != S_HALT),
        .inc_fetch   (load_fetch),
        .inc_bubble  (load_bubble),
        .inc_stall   ((state_q == S_RUN) && stall),
        .perf_fetch  (perf_fetch),
        .perf_bubble (perf_bubble),
        .perf_stall  (perf_stall)
    );
`else
    assign perf_fetch  = 32'h0;
    assign perf_bubble = 32'h0;
    assign perf_stall  = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage; imem returns addr ^ 0xC000_0000
// unless a single overridden word (used to plant beq/bne) matches the address.
module tb_if_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid, halt_req;
    logic [31:0] redirect_pc, imem_addr, imem_instr;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
    logic        if_id_valid, halted;
    logic [31:0] perf_fetch, perf_bubble, perf_stall;

    logic        ovr_en;
    logic [31:0] ovr_addr, ovr_word;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .perf_fetch     (perf_fetch),
        .perf_bubble    (perf_bubble),
        .perf_stall     (perf_stall)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_instr = imem_addr ^ 32'hC000_0000;
        if (ovr_en && (imem_addr == ovr_addr)) imem_instr = ovr_word;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_ifid(input string name, input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] addr);
        expect_word({name, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
        expect_word({name, "_instr"}, if_id_instr, instr);
        expect_word({name, "_pc"},    if_id_pc,    pc);
        expect_word({name, "_pc4"},   if_id_pc4,   pc + 32'd4);
        expect_word({name, "_addr"},  imem_addr,   addr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        halt_req = 1'b0; ovr_en = 1'b0; ovr_addr = '0; ovr_word = '0;
        #23;
        expect_word("rst_valid", {31'b0, if_id_valid}, 32'd0);
        expect_word("rst_instr", if_id_instr, 32'h0);
        expect_word("rst_pc",    if_id_pc,    32'h0);
        expect_word("rst_pc4",   if_id_pc4,   32'h4);
        expect_word("rst_addr",  imem_addr,   32'h0040_0000);
        expect_word("rst_halted", {31'b0, halted}, 32'd0);
        expect_word("rst_perf_fetch", perf_fetch, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_boot_fetch();
        step();
        expect_ifid("boot", 1'b0, 32'h0, 32'h0040_0000, 32'h0040_0000);
        step();
        expect_ifid("fetch0", 1'b1, 32'hC040_0000, 32'h0040_0000, 32'h0040_0004);
        step();
        expect_ifid("fetch1", 1'b1, 32'hC040_0004, 32'h0040_0004, 32'h0040_0008);
        step();
        expect_ifid("fetch2", 1'b1, 32'hC040_0008, 32'h0040_0008, 32'h0040_000C);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        step();
        expect_ifid("stall1", 1'b1, 32'hC040_0008, 32'h0040_0008, 32'h0040_000C);
        step();
        expect_ifid("stall2", 1'b1, 32'hC040_0008, 32'h0040_0008, 32'h0040_000C);
        expect_word("stall_perf", perf_stall, PERF_EN ? 32'd2 : 32'd0);
        stall = 1'b0;
        step();
        expect_ifid("post_stall", 1'b1, 32'hC040_000C, 32'h0040_000C, 32'h0040_0010);
    endtask

    task automatic test_redirect();
        ovr_en = 1'b1; ovr_addr = 32'h0040_0010; ovr_word = 32'h1000_0003;
        step();
        expect_ifid("beq_in_id", 1'b1, 32'h1000_0003, 32'h0040_0010, 32'h0040_0014);
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0043;
        step();
        expect_ifid("redir_bubble", 1'b0, 32'h0, 32'h0040_0014, 32'h0040_0040);
        redirect_valid = 1'b0;
        step();
        expect_ifid("redir_target", 1'b1, 32'hC040_0040, 32'h0040_0040, 32'h0040_0044);
    endtask

    task automatic test_branch_refetch();
        ovr_addr = 32'h0040_0044; ovr_word = 32'h1400_0007;
        step();
        expect_ifid("bne_in_id", 1'b1, 32'h1400_0007, 32'h0040_0044, 32'h0040_0048);
        step();
        expect_ifid("bne_bubble", 1'b0, 32'h0, 32'h0040_0048, 32'h0040_0048);
        step();
        expect_ifid("bne_refetch", 1'b1, 32'hC040_0048, 32'h0040_0048, 32'h0040_004C);
        ovr_en = 1'b0;
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0100; halt_req = 1'b1;
        step();
        expect_ifid("stall_wins", 1'b1, 32'hC040_0048, 32'h0040_0048, 32'h0040_004C);
        expect_word("stall_wins_halted", {31'b0, halted}, 32'd0);
        stall = 1'b0;
        step();
        expect_ifid("redir_over_halt", 1'b0, 32'h0, 32'h0040_004C, 32'h0040_0100);
        expect_word("redir_over_halt_halted", {31'b0, halted}, 32'd0);
        redirect_valid = 1'b0; halt_req = 1'b0;
        step();
        expect_ifid("late_redir_target", 1'b1, 32'hC040_0100, 32'h0040_0100, 32'h0040_0104);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        expect_word("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        expect_ifid("wrap_top", 1'b1, 32'h3FFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
        step();
        expect_ifid("wrap_zero", 1'b1, 32'hC000_0000, 32'h0000_0000, 32'h0000_0004);
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        step();
        expect_word("halt_halted", {31'b0, halted}, 32'd1);
        expect_ifid("halt_bubble", 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0004);
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_word("halt_hold_halted", {31'b0, halted}, 32'd1);
            expect_ifid("halt_hold", 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0004);
        end
        expect_word("halt_perf_fetch",  perf_fetch,  PERF_EN ? 32'd11 : 32'd0);
        expect_word("halt_perf_bubble", perf_bubble, PERF_EN ? 32'd6  : 32'd0);
        expect_word("halt_perf_stall",  perf_stall,  PERF_EN ? 32'd3  : 32'd0);
        rst_n = 1'b0;
        #1;
        expect_word("async_rst_addr",   imem_addr, 32'h0040_0000);
        expect_word("async_rst_halted", {31'b0, halted}, 32'd0);
        expect_word("async_rst_pc",     if_id_pc, 32'h0);
        expect_word("async_rst_perf",   perf_bubble, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        expect_ifid("reboot", 1'b0, 32'h0, 32'h0040_0000, 32'h0040_0000);
        step();
        expect_ifid("reboot_fetch", 1'b1, 32'hC040_0000, 32'h0040_0000, 32'h0040_0004);
    endtask

    initial begin
        test_reset();
        test_boot_fetch();
        test_stall();
        test_redirect();
        test_branch_refetch();
        test_stall_redirect();
        test_wrap();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register.
- Drives the instruction-memory address and latches the returned word (already bubbled for beq/bne) plus its PC into IF/ID for the decode stage.
- Applies hazard-unit stalls, ID-stage redirects (taken branch, j/jal/jr), branch-refetch and halt.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word written into IF/ID on flush or bubble.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  ID stage: control transfer taken this cycle.
- redirect_pc  in  32  target for redirect_valid.
- halt_req  in  1  stop fetching (break/testbench).
- imem_addr  out  32  address to instruction memory (= PC).
- imem_instr  in  32  word returned by instruction memory, same cycle.
- if_id_instr  out  32  IF/ID instruction register.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_pc4  out  32  if_id_pc + 4.
- if_id_valid  out  1  0 when IF/ID holds an inserted bubble.
- halted  out  1  high in S_HALT.
- perf_fetch, perf_bubble, perf_stall  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc4=4; if_id_valid=0; halted=0; state=S_BOOT; counters=0.
- imem_addr = PC, combinational; memory read is zero-latency; IF/ID updates on the clock edge after the fetch (1-cycle latency PC->ID).
- FSM states:
  - S_BOOT: single cycle after reset release; PC holds, IF/ID loads bubble; -> S_RUN.
  - S_RUN: normal fetch.
  - S_HALT: PC frozen; IF/ID loads bubble every cycle; exit only by reset.
- S_RUN priority per edge, highest first:
  1. stall=1: PC and all IF/ID fields hold. redirect_valid and halt_req ignored; the hazard unit guarantees they are re-presented.
  2. redirect_valid=1: PC<=redirect_pc; IF/ID<=bubble (valid=0, instr=NOP_INSTR).
  3. branch_in_id (if_id_instr[31:26] equals BEQ_OP or BNE_OP) with no redirect, i.e. not taken: PC holds so the squashed word is refetched; IF/ID<=bubble.
  4. halt_req=1: IF/ID<=bubble; PC holds; -> S_HALT.
  5. Otherwise: PC<=PC+4; IF/ID<={imem_instr, PC, PC+4}, valid=1.
- PC arithmetic: 32-bit modulo 2^32; PC 32'hFFFF_FFFC wraps to 0. PC[1:0] always 0: redirect_pc[1:0] are forced to 0 when loaded.
- A bubble loaded by rules 2-4 always carries if_id_pc/if_id_pc4 of the current PC, for debug.
- Simultaneous redirect and halt_req: redirect wins; halt is re-sampled next cycle.
- halted is registered: high from the first S_HALT cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, cleared on reset and frozen in S_HALT.
  - perf_fetch increments on each rule-5 load.
  - perf_bubble increments on each rule-2/3/4 load and on the S_BOOT cycle.
  - perf_stall increments on each rule-1 cycle.
- Not defined: no counter flops; the perf_* ports are tied to 0.

Decomposition:
- Shared package/def header: BEQ_OP=6'b000100, BNE_OP=6'b000101, NOP_INSTR value, RESET_PC default, FSM state encodings (S_BOOT=2'd0, S_RUN=2'd1, S_HALT=2'd2).
- Sub-module fetch_perf_counters holds the three counters inside the FETCH_PERF_CNT_EN guard.
- The IF/ID register stays inline.

Test Plan:
- Reset, then release with imem returning addr-indexed words: cycle 1 if_id_valid=0 (S_BOOT); afterwards if_id_pc=0x00400000, 0x00400004, ... with matching instr.
- Assert stall 2 cycles while IF/ID holds pc 0x00400008: PC and IF/ID unchanged both cycles; with the feature, perf_stall=2.
- beq latched in IF/ID, redirect_valid=1, redirect_pc=0x00400040: next IF/ID is a bubble; following IF/ID pc=0x00400040.
- bne latched in IF/ID with no redirect: one bubble, then the word at the bne's pc+4 appears (refetch), so no instruction is lost.
- stall and redirect_valid together: stall wins and nothing changes; redirect next cycle without stall is taken.
- halt_req in S_RUN: halted=1 next cycle, PC frozen, IF/ID bubbles indefinitely. Assert rst_n mid-halt: state returns to S_BOOT with PC=RESET_PC asynchronously.
